// File: rtl/vga_stream_arbiter_if.sv
// AXI4-Stream video beat bundle shared by the pixel sources and the VGA-side sink.
// The master drives the beat and tvalid; the slave drives tready.
interface vga_stream_arbiter_if #(
    parameter int TDATA_WIDTH = 16
);
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tuser;
    logic                   tlast;
    logic                   tvalid;
    logic                   tready;

    modport master (output tdata, tuser, tlast, tvalid, input  tready);
    modport slave  (input  tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/vga_stream_arbiter.sv
// Frame-aware 2:1 video stream arbiter; switches source only between frames, regenerates SOF/EOL.
// Latency 1 cycle accept->m_axis_tvalid; 2-entry skid, input tready is registered (skid not full).
module vga_stream_arbiter #(
    parameter int H_ACTIVE    = 800,
    parameter int V_ACTIVE    = 600,
    parameter int TDATA_WIDTH = 16,
    parameter bit DROP_UNSEL  = 1'b1
) (
    input  logic                 axi_clk,
    input  logic                 axi_rst,
    vga_stream_arbiter_if.slave  s0_axis,
    vga_stream_arbiter_if.slave  s1_axis,
    vga_stream_arbiter_if.master m_axis,
    input  logic                 sel_req,
    output logic                 active_sel,
    output logic                 streaming,
    output logic [15:0]          frame_count,
    output logic                 err_tlast,
    output logic                 err_sof,
    input  logic                 err_clr
);
    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    typedef struct packed {
        logic [TDATA_WIDTH-1:0] dat;
        logic                   user;
        logic                   last;
    } beat_t;

    state_t          state;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic            rdy_en;
    beat_t           out_q;
    beat_t           skid_q;
    logic            out_vld;
    logic            skid_vld;

    logic                   in_rdy;
    logic                   unsel_rdy;
    logic                   in_vld;
    logic [TDATA_WIDTH-1:0] in_dat;
    logic                   in_user;
    logic                   in_last;
    logic                   acc;

    // rdy_en holds tready low for the first cycle out of reset
    assign in_rdy    = rdy_en & ~skid_vld;
    assign unsel_rdy = DROP_UNSEL ? rdy_en : 1'b0;

    assign s0_axis.tready = active_sel ? unsel_rdy : in_rdy;
    assign s1_axis.tready = active_sel ? in_rdy : unsel_rdy;

    assign in_vld  = active_sel ? s1_axis.tvalid : s0_axis.tvalid;
    assign in_dat  = active_sel ? s1_axis.tdata  : s0_axis.tdata;
    assign in_user = active_sel ? s1_axis.tuser  : s0_axis.tuser;
    assign in_last = active_sel ? s1_axis.tlast  : s0_axis.tlast;
    assign acc     = in_vld & in_rdy;

    logic [XW-1:0] eff_x;
    logic [YW-1:0] eff_y;
    logic          line_end;
    logic          frame_end;
    logic          push;
    logic          set_tlast;
    logic          set_sof;
    beat_t         push_beat;

    // An incoming SOF restarts the raster at (0,0) before the beat is placed
    always_comb begin
        eff_x     = x;
        eff_y     = y;
        push      = 1'b0;
        set_tlast = 1'b0;
        set_sof   = 1'b0;
        if (in_user) begin
            eff_x = '0;
            eff_y = '0;
        end
        line_end  = (eff_x == X_LAST);
        frame_end = line_end && (eff_y == Y_LAST);
        if (state == IDLE) begin
            push = acc & in_user;
        end else begin
            push      = acc;
            set_tlast = acc & (in_last != line_end);
            set_sof   = acc & in_user & ((x != '0) || (y != '0));
        end
        push_beat.dat  = in_dat;
        push_beat.user = (eff_x == '0) && (eff_y == '0);
        push_beat.last = line_end;
    end

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            active_sel  <= 1'b0;
            streaming   <= 1'b0;
            frame_count <= '0;
            err_tlast   <= 1'b0;
            err_sof     <= 1'b0;
            rdy_en      <= 1'b0;
        end else begin
            rdy_en    <= 1'b1;
            err_tlast <= (err_tlast & ~err_clr) | set_tlast;
            err_sof   <= (err_sof & ~err_clr) | set_sof;
            // The SOF beat locks the source it came from, so hold the selection on that cycle
            if (state == IDLE && !push)
                active_sel <= sel_req;
            if (push) begin
                if (line_end) begin
                    x <= '0;
                    y <= frame_end ? '0 : eff_y + YW'(1);
                end else begin
                    x <= eff_x + XW'(1);
                    y <= eff_y;
                end
                if (frame_end) begin
                    frame_count <= frame_count + 16'd1;
                    state       <= IDLE;
                    streaming   <= 1'b0;
                end else begin
                    state       <= STREAM;
                    streaming   <= 1'b1;
                end
            end
        end
    end

    // push only happens with the skid empty, so a full skid never meets a new beat
    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
            out_q    <= '0;
            skid_q   <= '0;
        end else if (!out_vld || m_axis.tready) begin
            if (skid_vld) begin
                out_q    <= skid_q;
                out_vld  <= 1'b1;
                skid_vld <= 1'b0;
            end else if (push) begin
                out_q    <= push_beat;
                out_vld  <= 1'b1;
            end else begin
                out_vld  <= 1'b0;
            end
        end else if (push) begin
            skid_q   <= push_beat;
            skid_vld <= 1'b1;
        end
    end

    assign m_axis.tdata  = out_q.dat;
    assign m_axis.tuser  = out_q.user;
    assign m_axis.tlast  = out_q.last;
    assign m_axis.tvalid = out_vld;
endmodule

// File: tb/tb_vga_stream_arbiter.sv
// Directed bench for vga_stream_arbiter with a 4x2 raster: vector table plus hand-built corner sequences.
module tb_vga_stream_arbiter;
    localparam int H   = 4;
    localparam int V   = 2;
    localparam int TDW = 16;

    logic        axi_clk = 1'b0;
    logic        axi_rst = 1'b1;
    logic        sel_req = 1'b0;
    logic        err_clr = 1'b0;
    logic        active_sel;
    logic        streaming;
    logic [15:0] frame_count;
    logic        err_tlast;
    logic        err_sof;

    int n_vec = 0;
    int n_bad = 0;

    vga_stream_arbiter_if #(.TDATA_WIDTH(TDW)) s0_if ();
    vga_stream_arbiter_if #(.TDATA_WIDTH(TDW)) s1_if ();
    vga_stream_arbiter_if #(.TDATA_WIDTH(TDW)) m_if ();

    vga_stream_arbiter #(
        .H_ACTIVE(H), .V_ACTIVE(V), .TDATA_WIDTH(TDW), .DROP_UNSEL(1'b1)
    ) dut (
        .axi_clk(axi_clk), .axi_rst(axi_rst),
        .s0_axis(s0_if), .s1_axis(s1_if), .m_axis(m_if),
        .sel_req(sel_req), .active_sel(active_sel), .streaming(streaming),
        .frame_count(frame_count), .err_tlast(err_tlast), .err_sof(err_sof),
        .err_clr(err_clr)
    );

    always #5 axi_clk = ~axi_clk;

    typedef struct {
        logic        vld;
        logic [15:0] dat;
        logic        user;
        logic        last;
        logic        clr;
        logic        e_vld;
        logic [15:0] e_dat;
        logic        e_user;
        logic        e_last;
        logic        e_stream;
        logic        e_errt;
        logic [15:0] e_fc;
    } vec_t;

    vec_t tbl [22];

    function automatic vec_t mk(input logic vld, input logic [15:0] dat, input logic u, input logic l,
                                input logic clr, input logic ev, input logic [15:0] ed, input logic eu,
                                input logic el, input logic es, input logic et, input logic [15:0] efc);
        vec_t t;
        t.vld = vld; t.dat = dat; t.user = u; t.last = l; t.clr = clr;
        t.e_vld = ev; t.e_dat = ed; t.e_user = eu; t.e_last = el;
        t.e_stream = es; t.e_errt = et; t.e_fc = efc;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge axi_clk);
    endtask

    task automatic drive(input int src, input logic v, input logic [15:0] d, input logic u, input logic l);
        if (src == 0) begin
            s0_if.tvalid = v; s0_if.tdata = d; s0_if.tuser = u; s0_if.tlast = l;
        end else begin
            s1_if.tvalid = v; s1_if.tdata = d; s1_if.tuser = u; s1_if.tlast = l;
        end
    endtask

    initial begin
        logic [63:0] act;
        logic [63:0] exp;
        int          ri;
        int          si;
        int          cyc;
        logic        r;
        logic        held;
        logic        taken;
        logic [17:0] hold_b;

        drive(0, 1'b0, 16'h0, 1'b0, 1'b0);
        drive(1, 1'b0, 16'h0, 1'b0, 1'b0);
        m_if.tready = 1'b1;

        // dropped pre-SOF beats, a clean frame, then a frame with misplaced tlast and an err_clr
        tbl[0]  = mk(1, 16'hA000, 0, 0, 0,  0, 16'h0,    0, 0, 0, 0, 16'd0);
        tbl[1]  = mk(1, 16'hA001, 0, 1, 0,  0, 16'h0,    0, 0, 0, 0, 16'd0);
        tbl[2]  = mk(1, 16'hA002, 0, 0, 0,  0, 16'h0,    0, 0, 0, 0, 16'd0);
        tbl[3]  = mk(1, 16'hD000, 1, 0, 0,  1, 16'hD000, 1, 0, 1, 0, 16'd0);
        tbl[4]  = mk(1, 16'hD001, 0, 0, 0,  1, 16'hD001, 0, 0, 1, 0, 16'd0);
        tbl[5]  = mk(1, 16'hD002, 0, 0, 0,  1, 16'hD002, 0, 0, 1, 0, 16'd0);
        tbl[6]  = mk(1, 16'hD003, 0, 1, 0,  1, 16'hD003, 0, 1, 1, 0, 16'd0);
        tbl[7]  = mk(1, 16'hD004, 0, 0, 0,  1, 16'hD004, 0, 0, 1, 0, 16'd0);
        tbl[8]  = mk(1, 16'hD005, 0, 0, 0,  1, 16'hD005, 0, 0, 1, 0, 16'd0);
        tbl[9]  = mk(1, 16'hD006, 0, 0, 0,  1, 16'hD006, 0, 0, 1, 0, 16'd0);
        tbl[10] = mk(1, 16'hD007, 0, 1, 0,  1, 16'hD007, 0, 1, 0, 0, 16'd1);
        tbl[11] = mk(0, 16'h0,    0, 0, 0,  0, 16'h0,    0, 0, 0, 0, 16'd1);
        tbl[12] = mk(1, 16'hE000, 1, 0, 0,  1, 16'hE000, 1, 0, 1, 0, 16'd1);
        tbl[13] = mk(1, 16'hE001, 0, 0, 0,  1, 16'hE001, 0, 0, 1, 0, 16'd1);
        tbl[14] = mk(1, 16'hE002, 0, 1, 0,  1, 16'hE002, 0, 0, 1, 1, 16'd1);
        tbl[15] = mk(1, 16'hE003, 0, 0, 0,  1, 16'hE003, 0, 1, 1, 1, 16'd1);
        tbl[16] = mk(1, 16'hE004, 0, 0, 0,  1, 16'hE004, 0, 0, 1, 1, 16'd1);
        tbl[17] = mk(1, 16'hE005, 0, 0, 0,  1, 16'hE005, 0, 0, 1, 1, 16'd1);
        tbl[18] = mk(1, 16'hE006, 0, 0, 0,  1, 16'hE006, 0, 0, 1, 1, 16'd1);
        tbl[19] = mk(1, 16'hE007, 0, 1, 0,  1, 16'hE007, 0, 1, 0, 1, 16'd2);
        tbl[20] = mk(0, 16'h0,    0, 0, 1,  0, 16'h0,    0, 0, 0, 0, 16'd2);
        tbl[21] = mk(0, 16'h0,    0, 0, 0,  0, 16'h0,    0, 0, 0, 0, 16'd2);

        repeat (3) step();
        axi_rst = 1'b0;
        check("reset_state",
              64'({m_if.tvalid, s0_if.tready, s1_if.tready, streaming, active_sel, frame_count, err_tlast, err_sof}),
              64'(0));
        step();
        check("ready_after_reset", 64'({s0_if.tready, s1_if.tready}), 64'(2'b11));

        for (int i = 0; i < 22; i++) begin
            drive(0, tbl[i].vld, tbl[i].dat, tbl[i].user, tbl[i].last);
            err_clr = tbl[i].clr;
            step();
            act = 64'({m_if.tvalid, m_if.tvalid ? {m_if.tdata, m_if.tuser, m_if.tlast} : 18'h0,
                       streaming, err_tlast, frame_count});
            exp = 64'({tbl[i].e_vld, tbl[i].e_vld ? {tbl[i].e_dat, tbl[i].e_user, tbl[i].e_last} : 18'h0,
                       tbl[i].e_stream, tbl[i].e_errt, tbl[i].e_fc});
            check($sformatf("vec%0d", i), act, exp);
        end
        err_clr = 1'b0;

        // Two frames under random sink backpressure and bursty source valid
        ri = 0; si = 0; cyc = 0; held = 1'b0; taken = 1'b0; hold_b = '0;
        while (ri < 2 * H * V && cyc < 600) begin
            cyc++;
            if (held)
                check("stall_hold", 64'({m_if.tvalid, m_if.tdata, m_if.tuser, m_if.tlast}), 64'({1'b1, hold_b}));
            r = 1'($urandom_range(0, 1));
            m_if.tready = r;
            if (m_if.tvalid && r) begin
                check("rand_beat", 64'({m_if.tdata, m_if.tuser, m_if.tlast}),
                      64'({16'(16'h1000 + ri), (ri % (H * V)) == 0, (ri % H) == H - 1}));
                ri++;
            end
            held   = m_if.tvalid && !r;
            hold_b = {m_if.tdata, m_if.tuser, m_if.tlast};
            if (si < 2 * H * V) begin
                if (taken || !s0_if.tvalid)
                    s0_if.tvalid = ($urandom_range(0, 3) != 0);
                s0_if.tdata = 16'(16'h1000 + si);
                s0_if.tuser = (si % (H * V)) == 0;
                s0_if.tlast = (si % H) == H - 1;
                taken = s0_if.tvalid && s0_if.tready;
                if (taken) si++;
            end else begin
                s0_if.tvalid = 1'b0;
            end
            step();
        end
        s0_if.tvalid = 1'b0;
        m_if.tready  = 1'b1;
        check("rand_count", 64'(ri), 64'(2 * H * V));
        step();
        check("rand_done", 64'({m_if.tvalid, frame_count, err_tlast}), 64'({1'b0, 16'd4, 1'b0}));

        // Switch request mid-frame: s0 finishes its frame, s1 owns the next one
        for (int i = 0; i < H * V; i++) begin
            sel_req = (i >= 3);
            drive(0, 1'b1, 16'(16'hF000 + i), i == 0, (i % H) == H - 1);
            drive(1, 1'b1, 16'(16'hBAD0 + i), i == 1, 1'b0);
            step();
            check("sel_s0_beat", 64'({m_if.tvalid, m_if.tdata, m_if.tuser, m_if.tlast, active_sel}),
                  64'({1'b1, 16'(16'hF000 + i), i == 0, (i % H) == H - 1, 1'b0}));
        end
        check("unsel_drop_rdy", 64'(s1_if.tready), 64'(1));
        drive(0, 1'b0, 16'h0, 1'b0, 1'b0);
        drive(1, 1'b0, 16'h0, 1'b0, 1'b0);
        step();
        check("sel_switch", 64'({active_sel, streaming, frame_count}), 64'({1'b1, 1'b0, 16'd5}));
        for (int i = 0; i < H * V; i++) begin
            drive(1, 1'b1, 16'(16'h6000 + i), i == 0, (i % H) == H - 1);
            drive(0, 1'b1, 16'hDEAD, 1'b1, 1'b0);
            step();
            check("s1_frame", 64'({m_if.tvalid, m_if.tdata, m_if.tuser, m_if.tlast}),
                  64'({1'b1, 16'(16'h6000 + i), i == 0, (i % H) == H - 1}));
        end
        drive(0, 1'b0, 16'h0, 1'b0, 1'b0);
        drive(1, 1'b0, 16'h0, 1'b0, 1'b0);
        step();
        check("s1_frame_done", 64'({frame_count, err_sof, err_tlast}), 64'({16'd6, 1'b0, 1'b0}));

        // Mid-frame SOF restarts the raster from the offending beat
        for (int i = 0; i < 6; i++) begin
            drive(1, 1'b1, 16'(16'h7000 + i), (i == 0) || (i == 2), i == 5);
            step();
            check("mid_sof", 64'({m_if.tdata, m_if.tuser, m_if.tlast}),
                  64'({16'(16'h7000 + i), (i == 0) || (i == 2), i == 5}));
        end
        check("err_sof_flag", 64'({err_sof, err_tlast, streaming}), 64'({1'b1, 1'b0, 1'b1}));

        // Reset with a beat stalled in the output and one in the skid
        m_if.tready = 1'b0;
        drive(1, 1'b1, 16'h7006, 1'b0, 1'b0);
        step();
        axi_rst = 1'b1;
        drive(1, 1'b1, 16'h7007, 1'b0, 1'b0);
        step();
        check("reset_midframe",
              64'({m_if.tvalid, streaming, frame_count, active_sel, s1_if.tready, err_sof}), 64'(0));
        axi_rst = 1'b0;
        drive(1, 1'b0, 16'h0, 1'b0, 1'b0);
        m_if.tready = 1'b1;
        step();
        step();
        check("post_reset", 64'({m_if.tvalid, active_sel, s0_if.tready, s1_if.tready}), 64'(4'b0111));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
